// File: rtl/circuito_exp6_genius.sv
// Genius-style memory game: control FSM, datapath (round/play counters, ROM,
// comparator, button edge detector, timeout timer) and 7-segment debug encoders.
module circuito_exp6_genius #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_rodada,
  output logic       db_clock,
  output logic       db_jogada_correta,
  output logic       db_tem_jogada,
  output logic       db_enderecoIgualRodada,
  output logic       db_timeout
);

  localparam int unsigned TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam int unsigned CW       = 4;
  localparam int unsigned LAST_ROD = 15;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    NOVA_RODADA    = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } state_t;

  // Fixed game sequence
  function automatic logic [3:0] rom_data(input logic [CW-1:0] addr);
    logic [3:0] d;
    case (addr)
      4'd0:    d = 4'b0001;
      4'd1:    d = 4'b0010;
      4'd2:    d = 4'b0100;
      4'd3:    d = 4'b1000;
      4'd4:    d = 4'b0100;
      4'd5:    d = 4'b0010;
      4'd6:    d = 4'b0001;
      4'd7:    d = 4'b0001;
      4'd8:    d = 4'b0010;
      4'd9:    d = 4'b0010;
      4'd10:   d = 4'b0100;
      4'd11:   d = 4'b0100;
      4'd12:   d = 4'b1000;
      4'd13:   d = 4'b1000;
      4'd14:   d = 4'b0001;
      default: d = 4'b0100;
    endcase
    return d;
  endfunction

  // Hex glyphs, segments g..a on bits 6..0, active-low
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t        state, next_state;
  logic [CW-1:0] rodada, contagem;
  logic [3:0]    jogada;
  logic [TW-1:0] timer;
  logic          tem_jogada_q;

  logic jogada_pulso, jogada_correta, endereco_igual, timer_fim;
  logic zera_rodada, conta_rodada, zera_contagem, conta_contagem;
  logic zera_jogada, registra_jogada, zera_timer, conta_timer;

  assign db_tem_jogada  = |botoes;
  assign jogada_pulso   = db_tem_jogada & ~tem_jogada_q;
  assign jogada_correta = (jogada == rom_data(contagem));
  assign endereco_igual = (contagem == rodada);
  assign timer_fim      = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  always_comb begin
    next_state      = state;
    zera_rodada     = 1'b0;
    conta_rodada    = 1'b0;
    zera_contagem   = 1'b0;
    conta_contagem  = 1'b0;
    zera_jogada     = 1'b0;
    registra_jogada = 1'b0;
    zera_timer      = 1'b0;
    conta_timer     = 1'b0;
    case (state)
      INICIAL: if (jogar) next_state = PREPARACAO;
      PREPARACAO: begin
        zera_rodada   = 1'b1;
        zera_contagem = 1'b1;
        zera_jogada   = 1'b1;
        zera_timer    = 1'b1;
        next_state    = NOVA_RODADA;
      end
      NOVA_RODADA: begin
        zera_contagem = 1'b1;
        zera_timer    = 1'b1;
        next_state    = ESPERA_JOGADA;
      end
      // A press on the last timer cycle still counts as a play
      ESPERA_JOGADA: begin
        conta_timer = 1'b1;
        if (jogada_pulso)   next_state = REGISTRA;
        else if (timer_fim) next_state = FIM_TIMEOUT;
      end
      REGISTRA: begin
        registra_jogada = 1'b1;
        next_state      = COMPARA;
      end
      COMPARA: begin
        if (!jogada_correta)                  next_state = FIM_ERRO;
        else if (!endereco_igual)             next_state = PROXIMA_JOGADA;
        else if (rodada != CW'(LAST_ROD))     next_state = PROXIMA_RODADA;
        else                                  next_state = FIM_GANHOU;
      end
      PROXIMA_JOGADA: begin
        conta_contagem = 1'b1;
        zera_timer     = 1'b1;
        next_state     = ESPERA_JOGADA;
      end
      PROXIMA_RODADA: begin
        conta_rodada = 1'b1;
        next_state   = NOVA_RODADA;
      end
      FIM_GANHOU, FIM_TIMEOUT, FIM_ERRO: if (jogar) next_state = PREPARACAO;
      default: next_state = INICIAL;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      rodada       <= '0;
      contagem     <= '0;
      jogada       <= '0;
      timer        <= '0;
      tem_jogada_q <= 1'b0;
    end else begin
      tem_jogada_q <= db_tem_jogada;
      if (zera_rodada)         rodada <= '0;
      else if (conta_rodada)   rodada <= rodada + CW'(1);
      if (zera_contagem)       contagem <= '0;
      else if (conta_contagem) contagem <= contagem + CW'(1);
      if (zera_jogada)         jogada <= '0;
      else if (registra_jogada) jogada <= botoes;
      if (zera_timer)          timer <= '0;
      else if (conta_timer)    timer <= timer + TW'(1);
    end
  end

  // Status flags registered from the next state so they track the state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      pronto     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      ganhou     <= (next_state == FIM_GANHOU);
      perdeu     <= (next_state == FIM_ERRO) || (next_state == FIM_TIMEOUT);
      pronto     <= (next_state == FIM_GANHOU) || (next_state == FIM_ERRO) ||
                    (next_state == FIM_TIMEOUT);
      db_timeout <= (next_state == FIM_TIMEOUT);
    end
  end

  assign leds                   = jogada;
  assign db_clock               = clock;
  assign db_jogada_correta      = jogada_correta;
  assign db_enderecoIgualRodada = endereco_igual;
  assign db_contagem            = hex7seg(contagem);
  assign db_memoria             = hex7seg(rom_data(contagem));
  assign db_estado              = hex7seg(state);
  assign db_jogadafeita         = hex7seg(jogada);
  assign db_rodada              = hex7seg(rodada);

endmodule

// File: tb/tb_circuito_exp6_genius.sv
// Directed bench for the memory game: win, wrong play, timeout, restart,
// held button and mid-game reset.
module tb_circuito_exp6_genius;

  localparam int unsigned TO = 5000;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
  logic       db_clock, db_jogada_correta, db_tem_jogada, db_enderecoIgualRodada, db_timeout;

  int total = 0;
  int bad   = 0;

  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  circuito_exp6_genius #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_jogadafeita(db_jogadafeita), .db_rodada(db_rodada), .db_clock(db_clock),
    .db_jogada_correta(db_jogada_correta), .db_tem_jogada(db_tem_jogada),
    .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] b);
    botoes = b;
    tick(5);
    botoes = 4'h0;
    tick(5);
  endtask

  task automatic play_rounds(input int last);
    for (int r = 0; r <= last; r++)
      for (int i = 0; i <= r; i++) press(seq[i]);
  endtask

  // Leaves the game in espera_jogada, three edges after jogar is seen
  task automatic start_game();
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b0; jogar = 1'b0; botoes = 4'h0;
    tick(2);
    chk("rst_estado", 32'(db_estado), 32'h40);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
    chk("rst_rodada", 32'(db_rodada), 32'h40);
    chk("rst_memoria", 32'(db_memoria), 32'h79);
    reset = 1'b1;
    tick(1);

    // Full win
    jogar = 1'b1; tick(5); jogar = 1'b0;
    chk("start_estado", 32'(db_estado), 32'h30);
    play_rounds(15);
    chk("win_flags", 32'({ganhou, perdeu, pronto}), 32'b101);
    chk("win_estado", 32'(db_estado), 32'h08);
    chk("win_leds", 32'(leds), 32'h4);
    chk("win_rodada", 32'(db_rodada), 32'h0E);
    chk("win_contagem", 32'(db_contagem), 32'h0E);
    chk("win_dbg", 32'({db_jogada_correta, db_enderecoIgualRodada, db_timeout}), 32'b110);

    // Restart from fim_ganhou with jogar held
    jogar = 1'b1; tick(10); jogar = 1'b0;
    chk("restart_flags", 32'({ganhou, pronto}), 32'b00);
    chk("restart_rodada", 32'(db_rodada), 32'h40);
    chk("restart_estado", 32'(db_estado), 32'h30);
    chk("restart_leds", 32'(leds), 32'h0);

    // Held button in round 0, with compare latency
    botoes = 4'h1;
    tick(1);
    chk("held_tem", 32'(db_tem_jogada), 32'h1);
    chk("held_registra", 32'(db_estado), 32'h19);
    tick(1);
    chk("held_compara", 32'(db_estado), 32'h12);
    chk("held_leds", 32'(leds), 32'h1);
    chk("held_correta", 32'(db_jogada_correta), 32'h1);
    tick(18);
    botoes = 4'h0;
    tick(5);
    chk("held_rodada", 32'(db_rodada), 32'h79);
    chk("held_contagem", 32'(db_contagem), 32'h40);
    chk("held_estado", 32'(db_estado), 32'h30);
    jogar = 1'b1; tick(3); jogar = 1'b0; tick(1);
    chk("jogar_ignored", 32'({db_estado, db_rodada}), 32'({7'h30, 7'h79}));

    // Wrong play in round 3
    reset = 1'b0; tick(1); reset = 1'b1;
    start_game();
    play_rounds(2);
    press(seq[0]);
    press(seq[1]);
    press(4'h1);
    chk("err_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'b0110);
    chk("err_estado", 32'(db_estado), 32'h06);
    chk("err_leds", 32'(leds), 32'h1);
    chk("err_rodada", 32'(db_rodada), 32'h30);
    chk("err_contagem", 32'(db_contagem), 32'h24);

    // Timeout boundary
    start_game();
    chk("to_clear", 32'({perdeu, pronto}), 32'b00);
    tick(TO - 1);
    chk("to_before", 32'({db_estado, db_timeout}), 32'({7'h30, 1'b0}));
    tick(1);
    chk("to_estado", 32'(db_estado), 32'h21);
    chk("to_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'b0111);

    // Reset in the middle of round 5
    start_game();
    play_rounds(4);
    press(seq[0]);
    press(seq[1]);
    chk("mid_rodada", 32'(db_rodada), 32'h12);
    chk("mid_contagem", 32'(db_contagem), 32'h24);
    reset = 1'b0;
    tick(1);
    chk("mrst_estado", 32'(db_estado), 32'h40);
    chk("mrst_rodada", 32'(db_rodada), 32'h40);
    chk("mrst_contagem", 32'(db_contagem), 32'h40);
    chk("mrst_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
    chk("mrst_leds", 32'(leds), 32'h0);
    reset = 1'b1;
    tick(2);
    chk("idle_estado", 32'(db_estado), 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
